// File: rtl/split_bus_arbiter.sv
// Central bus arbiter: two initiators plus a split-capable target, with
// split parking of the owning initiator and a watchdog that aborts stale splits.
module split_bus_arbiter #(
  parameter int unsigned SPLIT_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       bus_split_ack,
  input  logic       split_req,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       split_grant,
  output logic [1:0] bus_owner,
  output logic       m1_split,
  output logic       m2_split,
  output logic       split_abort
);

  localparam int unsigned CW = $clog2(SPLIT_TIMEOUT + 1);

  // Encoding doubles as the bus_owner code.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GNT_M1    = 2'd1,
    GNT_M2    = 2'd2,
    GNT_SPLIT = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          pend, pend_nxt;
  logic          owner2, owner2_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          abort_nxt;
  logic          m1_parked, m2_parked;

  assign m1_parked = pend && !owner2;
  assign m2_parked = pend && owner2;

  always_comb begin
    state_nxt  = state;
    pend_nxt   = pend;
    owner2_nxt = owner2;
    cnt_nxt    = cnt;
    abort_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (pend && split_req)          state_nxt = GNT_SPLIT;
        else if (m1_req && !m1_parked)  state_nxt = GNT_M1;
        else if (m2_req && !m2_parked)  state_nxt = GNT_M2;
      end
      GNT_M1: begin
        if (bus_split_ack && !pend) begin
          state_nxt  = IDLE;
          pend_nxt   = 1'b1;
          owner2_nxt = 1'b0;
          cnt_nxt    = '0;
        end else if (!m1_req) begin
          state_nxt = IDLE;
        end
      end
      GNT_M2: begin
        if (bus_split_ack && !pend) begin
          state_nxt  = IDLE;
          pend_nxt   = 1'b1;
          owner2_nxt = 1'b1;
          cnt_nxt    = '0;
        end else if (!m2_req) begin
          state_nxt = IDLE;
        end
      end
      GNT_SPLIT: begin
        if (!split_req) begin
          state_nxt = IDLE;
          pend_nxt  = 1'b0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Watchdog: frozen while the target holds the bus, and a reclaim on the
    // same cycle takes precedence over the abort.
    if (pend && state != GNT_SPLIT && state_nxt != GNT_SPLIT) begin
      if (cnt == CW'(SPLIT_TIMEOUT - 1)) begin
        pend_nxt  = 1'b0;
        cnt_nxt   = '0;
        abort_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pend        <= 1'b0;
      owner2      <= 1'b0;
      cnt         <= '0;
      m1_grant    <= 1'b0;
      m2_grant    <= 1'b0;
      split_grant <= 1'b0;
      bus_owner   <= 2'd0;
      m1_split    <= 1'b0;
      m2_split    <= 1'b0;
      split_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend        <= pend_nxt;
      owner2      <= owner2_nxt;
      cnt         <= cnt_nxt;
      m1_grant    <= (state_nxt == GNT_M1);
      m2_grant    <= (state_nxt == GNT_M2);
      split_grant <= (state_nxt == GNT_SPLIT);
      bus_owner   <= state_nxt;
      m1_split    <= pend_nxt && !owner2_nxt;
      m2_split    <= pend_nxt && owner2_nxt;
      split_abort <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Directed bench for split_bus_arbiter with SPLIT_TIMEOUT=8.
module tb_split_bus_arbiter;

  logic       clk;
  logic       rst;
  logic       m1_req, m2_req, bus_split_ack, split_req;
  logic       m1_grant, m2_grant, split_grant;
  logic [1:0] bus_owner;
  logic       m1_split, m2_split, split_abort;

  int n_chk  = 0;
  int n_fail = 0;

  split_bus_arbiter #(.SPLIT_TIMEOUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .m1_req        (m1_req),
    .m2_req        (m2_req),
    .bus_split_ack (bus_split_ack),
    .split_req     (split_req),
    .m1_grant      (m1_grant),
    .m2_grant      (m2_grant),
    .split_grant   (split_grant),
    .bus_owner     (bus_owner),
    .m1_split      (m1_split),
    .m2_split      (m2_split),
    .split_abort   (split_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] obs;
  assign obs = {m1_grant, m2_grant, split_grant, bus_owner, m1_split, m2_split, split_abort};

  function automatic logic [7:0] vec(input int g1, input int g2, input int gs,
                                     input int own, input int s1, input int s2,
                                     input int ab);
    return {g1[0], g2[0], gs[0], own[1:0], s1[0], s2[0], ab[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output order: m1_grant m2_grant split_grant bus_owner[1:0] m1_split m2_split split_abort
  task automatic chk(input string tag, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; m1_req = 1'b0; m2_req = 1'b0; bus_split_ack = 1'b0; split_req = 1'b0;
    tick();
    chk("reset", vec(0,0,0,0,0,0,0));
    rst = 1'b0;
    tick();
    chk("idle_after_reset", vec(0,0,0,0,0,0,0));

    // Priority and mandatory handover gap
    m1_req = 1'b1; m2_req = 1'b1;
    tick(); chk("prio_m1", vec(1,0,0,1,0,0,0));
    tick(); chk("m1_hold_vs_m2", vec(1,0,0,1,0,0,0));
    m1_req = 1'b0;
    tick(); chk("handover_gap", vec(0,0,0,0,0,0,0));
    tick(); chk("m2_granted", vec(0,1,0,2,0,0,0));
    m1_req = 1'b1;
    tick(); chk("no_preempt", vec(0,1,0,2,0,0,0));
    m2_req = 1'b0;
    tick(); chk("m2_release", vec(0,0,0,0,0,0,0));
    tick(); chk("m1_regrant", vec(1,0,0,1,0,0,0));

    // Split of m1, reuse by m2, ignored second ack, reclaim
    bus_split_ack = 1'b1;
    tick(); chk("m1_split", vec(0,0,0,0,1,0,0));
    bus_split_ack = 1'b0;
    tick(); chk("m1_parked_ignored", vec(0,0,0,0,1,0,0));
    m2_req = 1'b1;
    tick(); chk("m2_while_parked", vec(0,1,0,2,1,0,0));
    bus_split_ack = 1'b1;
    tick(); chk("second_ack_ignored", vec(0,1,0,2,1,0,0));
    bus_split_ack = 1'b0;
    m2_req = 1'b0;
    tick(); chk("m2_done", vec(0,0,0,0,1,0,0));
    split_req = 1'b1;
    tick(); chk("reclaim", vec(0,0,1,3,1,0,0));
    tick(); chk("reclaim_hold", vec(0,0,1,3,1,0,0));
    split_req = 1'b0;
    tick(); chk("reclaim_done", vec(0,0,0,0,0,0,0));
    tick(); chk("m1_after_split", vec(1,0,0,1,0,0,0));
    m1_req = 1'b0;
    tick(); chk("m1_release", vec(0,0,0,0,0,0,0));

    // split_req without a pending split
    split_req = 1'b1;
    tick(); chk("split_req_no_pend", vec(0,0,0,0,0,0,0));
    tick(); chk("split_req_no_pend2", vec(0,0,0,0,0,0,0));
    split_req = 1'b0;

    // Timeout of an m2 split
    m2_req = 1'b1;
    tick(); chk("m2_grant_to", vec(0,1,0,2,0,0,0));
    bus_split_ack = 1'b1;
    tick(); chk("m2_split", vec(0,0,0,0,0,1,0));
    bus_split_ack = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick(); chk($sformatf("to_pending_%0d", i), vec(0,0,0,0,0,1,0));
    end
    tick(); chk("to_abort", vec(0,0,0,0,0,0,1));
    tick(); chk("to_m2_regrant", vec(0,1,0,2,0,0,0));
    m2_req = 1'b0;
    tick(); chk("to_m2_release", vec(0,0,0,0,0,0,0));

    // Reset during GNT_SPLIT discards the split silently
    m1_req = 1'b1;
    tick(); chk("rst_m1_grant", vec(1,0,0,1,0,0,0));
    bus_split_ack = 1'b1;
    tick(); chk("rst_m1_split", vec(0,0,0,0,1,0,0));
    bus_split_ack = 1'b0; m1_req = 1'b0; split_req = 1'b1;
    tick(); chk("rst_reclaim", vec(0,0,1,3,1,0,0));
    rst = 1'b1;
    tick(); chk("rst_mid_split", vec(0,0,0,0,0,0,0));
    rst = 1'b0; split_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); chk($sformatf("post_rst_quiet_%0d", i), vec(0,0,0,0,0,0,0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
